// File: rtl/aes_host_ctrl_if.sv
// Host-side bundle for aes_host_ctrl: upstream request/response, key config,
// and the command/data port of the aes core.
interface aes_host_ctrl_if;
  logic [255:0] cfg_key;
  logic [1:0]   cfg_key_mode;
  logic         cfg_load;
  logic         req_valid;
  logic         req_ready;
  logic [127:0] req_data;
  logic         req_ende;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_ende;
  logic         err;
  logic         i_start;
  logic         i_enable;
  logic         i_ende;
  logic [255:0] i_key;
  logic [1:0]   i_key_mode;
  logic [127:0] i_data;
  logic         i_data_valid;
  logic         o_ready;
  logic         o_key_ready;
  logic         o_data_valid;
  logic [127:0] o_data;

  modport master (
    input  cfg_key, cfg_key_mode, cfg_load, req_valid, req_data, req_ende, rsp_ready,
           o_ready, o_key_ready, o_data_valid, o_data,
    output req_ready, rsp_valid, rsp_data, rsp_ende, err,
           i_start, i_enable, i_ende, i_key, i_key_mode, i_data, i_data_valid
  );

  modport slave (
    output cfg_key, cfg_key_mode, cfg_load, req_valid, req_data, req_ende, rsp_ready,
           o_ready, o_key_ready, o_data_valid, o_data,
    input  req_ready, rsp_valid, rsp_data, rsp_ende, err,
           i_start, i_enable, i_ende, i_key, i_key_mode, i_data, i_data_valid
  );
endinterface

// File: rtl/aes_host_ctrl.sv
// Initiator for the aes core: key load, credit-limited block issue, response FIFO,
// progress timeout with a sticky error.
module aes_host_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            reset,
  aes_host_ctrl_if.master bus
);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, KEY_LOAD, KEY_WAIT, RUN, ERROR} state_t;

  state_t         state_q, state_d;
  logic [255:0]   key_q, key_d;
  logic [1:0]     key_mode_q, key_mode_d;
  logic [127:0]   i_data_q, i_data_d;
  logic           i_data_valid_q, i_data_valid_d;
  logic           cur_ende_q, cur_ende_d;
  logic           load_pending_q, load_pending_d;
  logic           err_q, err_d;
  logic [OW-1:0]  outstanding_q, outstanding_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [OW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [128:0]   mem_q [DEPTH];

  logic [OW:0]    used;
  logic [TW-1:0]  timer_inc;
  logic           dir_block, req_ready, accept, push, pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    used      = {1'b0, outstanding_q} + {1'b0, cnt_q};
    // Mixing directions in flight would mis-tag results, so a switch drains first.
    dir_block = (outstanding_q != '0) && (bus.req_ende != cur_ende_q);
    req_ready = (state_q == RUN) && bus.o_ready && (used < (OW + 1)'(DEPTH))
                && !load_pending_q && !dir_block;
    accept    = req_ready && bus.req_valid;
    pop       = (cnt_q != '0) && bus.rsp_ready;
    timer_inc = (timer_q == TW'(TIMEOUT)) ? timer_q : timer_q + TW'(1);

    state_d        = state_q;
    key_d          = key_q;
    key_mode_d     = key_mode_q;
    i_data_d       = i_data_q;
    i_data_valid_d = 1'b0;
    cur_ende_d     = cur_ende_q;
    load_pending_d = load_pending_q;
    err_d          = err_q;
    outstanding_d  = outstanding_q;
    timer_d        = timer_q;
    push           = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cfg_load) begin
          key_d      = bus.cfg_key;
          key_mode_d = bus.cfg_key_mode;
          state_d    = KEY_LOAD;
        end
      end
      KEY_LOAD: begin
        timer_d = '0;
        state_d = KEY_WAIT;
      end
      KEY_WAIT: begin
        if (bus.o_key_ready) begin
          timer_d = '0;
          state_d = RUN;
        end else begin
          timer_d = timer_inc;
          if (timer_inc == TW'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = ERROR;
          end
        end
      end
      RUN: begin
        if (accept) begin
          i_data_d       = bus.req_data;
          cur_ende_d     = bus.req_ende;
          i_data_valid_d = 1'b1;
        end
        push          = bus.o_data_valid && (outstanding_q != '0);
        outstanding_d = outstanding_q + OW'(accept) - OW'(push);
        if (bus.cfg_load) begin
          key_d          = bus.cfg_key;
          key_mode_d     = bus.cfg_key_mode;
          load_pending_d = 1'b1;
        end
        if ((outstanding_q != '0) && !bus.o_data_valid) begin
          timer_d = timer_inc;
          if (timer_inc == TW'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = ERROR;
          end
        end else begin
          timer_d = '0;
          if (load_pending_q && (outstanding_q == '0)) begin
            load_pending_d = 1'b0;
            state_d        = KEY_LOAD;
          end
        end
      end
      ERROR: begin
        if (bus.cfg_load) begin
          key_d          = bus.cfg_key;
          key_mode_d     = bus.cfg_key_mode;
          err_d          = 1'b0;
          outstanding_d  = '0;
          timer_d        = '0;
          load_pending_d = 1'b0;
          state_d        = KEY_LOAD;
        end
      end
      default: state_d = IDLE;
    endcase

    // A response nobody asked for is dropped and faults the controller.
    if ((state_q != ERROR) && bus.o_data_valid && (outstanding_q == '0)) begin
      err_d          = 1'b1;
      load_pending_d = 1'b0;
      state_d        = ERROR;
    end

    cnt_d    = cnt_q + OW'(push) - OW'(pop);
    wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      key_q          <= '0;
      key_mode_q     <= '0;
      i_data_q       <= '0;
      i_data_valid_q <= 1'b0;
      cur_ende_q     <= 1'b0;
      load_pending_q <= 1'b0;
      err_q          <= 1'b0;
      outstanding_q  <= '0;
      timer_q        <= '0;
      cnt_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
    end else begin
      state_q        <= state_d;
      key_q          <= key_d;
      key_mode_q     <= key_mode_d;
      i_data_q       <= i_data_d;
      i_data_valid_q <= i_data_valid_d;
      cur_ende_q     <= cur_ende_d;
      load_pending_q <= load_pending_d;
      err_q          <= err_d;
      outstanding_q  <= outstanding_d;
      timer_q        <= timer_d;
      cnt_q          <= cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cur_ende_q, bus.o_data};
  end

  assign bus.req_ready    = req_ready;
  assign bus.rsp_valid    = (cnt_q != '0);
  assign bus.rsp_data     = (cnt_q != '0) ? mem_q[rd_ptr_q][127:0] : '0;
  assign bus.rsp_ende     = (cnt_q != '0) ? mem_q[rd_ptr_q][128]   : 1'b0;
  assign bus.err          = err_q;
  assign bus.i_start      = (state_q == KEY_LOAD);
  assign bus.i_enable     = (state_q == KEY_LOAD) || (state_q == KEY_WAIT) || (state_q == RUN);
  assign bus.i_ende       = cur_ende_q;
  assign bus.i_key        = key_q;
  assign bus.i_key_mode   = key_mode_q;
  assign bus.i_data       = i_data_q;
  assign bus.i_data_valid = i_data_valid_q;
endmodule

// File: tb/tb_aes_host_ctrl.sv
// Directed bench for aes_host_ctrl: key load, round-trip, credit, direction switch,
// unexpected response, timeout and reset.
module tb_aes_host_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  aes_host_ctrl_if bus();
  aes_host_ctrl #(.DEPTH(4), .TIMEOUT(1024)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    #1;
    checks++; if (bus.i_enable !== 1'b0) begin errors++; $display("FAIL reset_i_enable got %b want 0", bus.i_enable); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    checks++; if (bus.i_key !== 256'h0) begin errors++; $display("FAIL reset_i_key got %h want 0", bus.i_key); end
    checks++; if (bus.err !== 1'b0 || bus.i_start !== 1'b0 || bus.i_data_valid !== 1'b0)
      begin errors++; $display("FAIL reset_ctrl err=%b start=%b dv=%b want 0", bus.err, bus.i_start, bus.i_data_valid); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_key_load;
    logic held_low;
    bus.cfg_key = 256'h0; bus.cfg_key_mode = 2'b00; bus.o_ready = 1'b1; bus.cfg_load = 1'b1;
    tick();
    bus.cfg_load = 1'b0;
    #1;
    checks++; if (bus.i_start !== 1'b1 || bus.i_enable !== 1'b1)
      begin errors++; $display("FAIL key_start got start=%b en=%b want 1 1", bus.i_start, bus.i_enable); end
    tick();
    #1;
    checks++; if (bus.i_start !== 1'b0) begin errors++; $display("FAIL key_start_width got %b want 0", bus.i_start); end
    held_low = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.req_ready !== 1'b0 || bus.i_enable !== 1'b1) held_low = 1'b0;
      tick();
    end
    bus.o_key_ready = 1'b1;
    #1;
    if (bus.req_ready !== 1'b0) held_low = 1'b0;
    checks++; if (held_low !== 1'b1) begin errors++; $display("FAIL key_wait_ready got early ready want 0"); end
    tick();
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL key_ready_rise got %b want 1", bus.req_ready); end
  endtask

  task automatic test_encrypt;
    bus.req_data = 128'h63da_49b0; bus.req_ende = 1'b0; bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    #1;
    checks++; if (bus.i_data_valid !== 1'b1 || bus.i_data !== 128'h63da_49b0 || bus.i_ende !== 1'b0)
      begin errors++; $display("FAIL enc_issue got dv=%b data=%h ende=%b want 1 63da49b0 0", bus.i_data_valid, bus.i_data, bus.i_ende); end
    tick();
    #1;
    checks++; if (bus.i_data_valid !== 1'b0) begin errors++; $display("FAIL enc_dv_pulse got %b want 0", bus.i_data_valid); end
    repeat (8) tick();
    bus.o_data_valid = 1'b1; bus.o_data = 128'h4368_1570;
    tick();
    bus.o_data_valid = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 128'h4368_1570 || bus.rsp_ende !== 1'b0)
      begin errors++; $display("FAIL enc_rsp got v=%b data=%h ende=%b want 1 43681570 0", bus.rsp_valid, bus.rsp_data, bus.rsp_ende); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL enc_pop got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_credit;
    int acc = 0;
    bus.rsp_ready = 1'b0; bus.req_ende = 1'b0; bus.req_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.req_data = 128'(100 + acc);
      #1;
      if (bus.req_ready === 1'b1) acc++;
      tick();
    end
    checks++; if (acc !== 4) begin errors++; $display("FAIL credit_accepts got %0d want 4", acc); end
    for (int k = 0; k < 4; k++) begin
      bus.o_data_valid = 1'b1; bus.o_data = 128'(200 + k);
      tick();
    end
    bus.o_data_valid = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL credit_fifo_full got %b want 0", bus.req_ready); end
    checks++; if (bus.rsp_data !== 128'd200) begin errors++; $display("FAIL credit_head got %0d want 200", bus.rsp_data); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL credit_after_pop got %b want 1", bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    #1;
    checks++; if (bus.i_data_valid !== 1'b1 || bus.i_data !== 128'd104)
      begin errors++; $display("FAIL credit_fifth got dv=%b data=%0d want 1 104", bus.i_data_valid, bus.i_data); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL credit_refull got %b want 0", bus.req_ready); end
    bus.o_data_valid = 1'b1; bus.o_data = 128'd204;
    tick();
    bus.o_data_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++; if (bus.rsp_data !== 128'(200 + k))
        begin errors++; $display("FAIL credit_drain%0d got %0d want %0d", k, bus.rsp_data, 200 + k); end
      tick();
    end
    bus.rsp_ready = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL credit_empty got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_direction;
    logic exp_ende [3];
    exp_ende[0] = 1'b0; exp_ende[1] = 1'b0; exp_ende[2] = 1'b1;
    bus.req_ende = 1'b0; bus.req_valid = 1'b1; bus.req_data = 128'hA0;
    tick();
    bus.req_data = 128'hA1;
    tick();
    bus.req_ende = 1'b1; bus.req_data = 128'hD0;
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL dir_hold2 got %b want 0", bus.req_ready); end
    bus.o_data_valid = 1'b1; bus.o_data = 128'hE0;
    tick();
    bus.o_data_valid = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL dir_hold1 got %b want 0", bus.req_ready); end
    bus.o_data_valid = 1'b1; bus.o_data = 128'hE1;
    tick();
    bus.o_data_valid = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL dir_release got %b want 1", bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    #1;
    checks++; if (bus.i_data_valid !== 1'b1 || bus.i_ende !== 1'b1 || bus.i_data !== 128'hD0)
      begin errors++; $display("FAIL dir_issue got dv=%b ende=%b data=%h want 1 1 d0", bus.i_data_valid, bus.i_ende, bus.i_data); end
    bus.o_data_valid = 1'b1; bus.o_data = 128'hF0;
    tick();
    bus.o_data_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_ende !== exp_ende[k])
        begin errors++; $display("FAIL dir_tag%0d got v=%b ende=%b want 1 %b", k, bus.rsp_valid, bus.rsp_ende, exp_ende[k]); end
      tick();
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_unexpected;
    bus.o_data_valid = 1'b1; bus.o_data = 128'hBAD;
    tick();
    bus.o_data_valid = 1'b0;
    #1;
    checks++; if (bus.err !== 1'b1 || bus.i_enable !== 1'b0 || bus.req_ready !== 1'b0)
      begin errors++; $display("FAIL unexp_err got err=%b en=%b rdy=%b want 1 0 0", bus.err, bus.i_enable, bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL unexp_dropped got %b want 0", bus.rsp_valid); end
    bus.cfg_key = {8{32'hC0FFEE01}}; bus.cfg_key_mode = 2'b10; bus.cfg_load = 1'b1;
    tick();
    bus.cfg_load = 1'b0;
    #1;
    checks++; if (bus.err !== 1'b0 || bus.i_start !== 1'b1 || bus.i_key !== {8{32'hC0FFEE01}} || bus.i_key_mode !== 2'b10)
      begin errors++; $display("FAIL unexp_reload got err=%b start=%b mode=%b want 0 1 10", bus.err, bus.i_start, bus.i_key_mode); end
    tick();
    tick();
  endtask

  task automatic test_timeout_reset;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL to_run got %b want 1", bus.req_ready); end
    bus.req_ende = 1'b0; bus.req_data = 128'h77; bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    repeat (1023) tick();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", bus.err); end
    tick();
    checks++; if (bus.err !== 1'b1 || bus.i_enable !== 1'b0)
      begin errors++; $display("FAIL to_err got err=%b en=%b want 1 0", bus.err, bus.i_enable); end
    reset = 1'b1;
    tick();
    #1;
    checks++; if (bus.err !== 1'b0 || bus.i_key !== 256'h0 || bus.i_data !== 128'h0 || bus.i_key_mode !== 2'b00)
      begin errors++; $display("FAIL rst_mid got err=%b key=%h data=%h want zeros", bus.err, bus.i_key, bus.i_data); end
    checks++; if (bus.i_enable !== 1'b0 || bus.req_ready !== 1'b0 || bus.i_start !== 1'b0 || bus.rsp_valid !== 1'b0)
      begin errors++; $display("FAIL rst_ctrl got en=%b rdy=%b start=%b rv=%b want 0", bus.i_enable, bus.req_ready, bus.i_start, bus.rsp_valid); end
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.cfg_key = '0; bus.cfg_key_mode = '0; bus.cfg_load = 1'b0;
    bus.req_valid = 1'b0; bus.req_data = '0; bus.req_ende = 1'b0; bus.rsp_ready = 1'b0;
    bus.o_ready = 1'b0; bus.o_key_ready = 1'b0; bus.o_data_valid = 1'b0; bus.o_data = '0;
    test_reset();
    test_key_load();
    test_encrypt();
    test_credit();
    test_direction();
    test_unexpected();
    test_timeout_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
